fp16_div: RTL and testbench
===========================

FP16_DIV -- requirements
Module: fp16_div

Interface
REQ-001 SHALL have parameter ITER, default 13, number of quotient bits produced (one per cycle).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b are presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  16  IEEE-754 binary16 dividend.
REQ-007 SHALL have port b  input  16  IEEE-754 binary16 divisor.
REQ-008 SHALL have port out_valid  output  1  x and flags are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port x  output  16  binary16 quotient a/b.
REQ-011 SHALL have port flags  output  4  {inv, dz, ovf, unf}, valid with out_valid.

Function
REQ-012 SHALL use FSM states IDLE, DIV, NORM, DONE; in_ready=1 only in IDLE.
REQ-013 SHALL accept on an edge with in_valid&&in_ready, registering sign=a[15]^b[15], significands, and exponent e=ea-eb+15 (7-bit signed).
REQ-014 SHALL treat inputs with exponent 0 as signed zero (subnormals flushed).
REQ-015 SHALL resolve special cases at acceptance and go directly to DONE: any NaN, 0/0 or inf/inf -> 16'h7E00, inv=1; finite/0 -> signed inf, dz=1; inf/finite -> signed inf; finite/inf or 0/nonzero -> signed zero.
REQ-016 SHALL otherwise enter DIV and perform ITER restoring radix-2 steps of {1,ma}/{1,mb}, one quotient bit per cycle, MSB first, producing q[12:0] (q[12] integer bit) and remainder r.
REQ-017 In NORM: if q[12]=1 mantissa=q[11:2], guard=q[1], sticky=q[0]|(r!=0); else mantissa=q[10:1], guard=q[0], sticky=(r!=0), e=e-1.
REQ-018 SHALL round to nearest, ties to even; rounding carry out of mantissa SHALL increment e and zero the mantissa.
REQ-019 SHALL produce signed inf with ovf=1 if final e>=31; signed zero with unf=1 if final e<=0.
REQ-020 Latency: special case out_valid=1 from the accepting edge; normal case from the 14th rising edge after the accepting edge (DIV 13 cycles, NORM 1).
REQ-021 SHALL hold x, flags, out_valid stable in DONE while out_ready=0; on out_valid&&out_ready return to IDLE (in_ready=1 next cycle; no same-cycle accept).
REQ-022 SHALL ignore in_valid and operand changes outside IDLE.

Reset
REQ-023 On rst=1 at a rising edge SHALL enter IDLE with x=16'h0000, flags=4'b0000, out_valid=0, in_ready=1, iteration counter 0.
REQ-024 Reset mid-operation (DIV, NORM or DONE) SHALL abandon the operation; no result is emitted.
REQ-025 rst SHALL take priority over all handshakes in the same cycle.

Structure
REQ-026 Shared package fp16_pkg SHALL hold BIAS=15, EXP_MAX=31, QNAN=16'h7E00, state enum, and flag bit positions.
REQ-027 Special-case classification SHALL be a sub-module fp16_classify (zero/inf/nan per operand), reusable by fp16mult.
REQ-028 Iterative datapath and FSM SHALL remain in fp16_div; no combinational divider array.

Verification
REQ-029 a=16'h4200 (3.0), b=16'h3E00 (1.5) -> x=16'h4000, flags=0, out_valid 14 edges after accept.
REQ-030 a=16'h3C00, b=16'h4200 -> x=16'h3555 (RNE of 1/3), flags=0.
REQ-031 a=16'h3C00, b=16'h0000 -> x=16'h7C00, dz=1, out_valid on accepting edge; a=16'h0000, b=16'h8000 -> x=16'h7E00, inv=1.
REQ-032 a=16'h7BFF, b=16'h0400 -> x=16'h7C00, ovf=1; a=16'h0400, b=16'h7BFF -> x=16'h0000, unf=1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> x, flags stable, in_ready=0; assertion with new in_valid -> no accept until IDLE.
REQ-034 rst=1 during DIV cycle 6 -> next cycle in_ready=1, out_valid=0, x=0; subsequent 3.0/1.5 division correct.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16 shared definitions: constants, FSM states,
// flag bit positions and operand classification.
package fp16_pkg;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;

  localparam int F_INV = 3;
  localparam int F_DZ  = 2;
  localparam int F_OVF = 1;
  localparam int F_UNF = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } cls_t;
endpackage

// File: rtl/fp16_div_if.sv
// fp16 divider operand/result handshake bundle.
// master is the requester, slave is the divider.
interface fp16_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic [3:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, x, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, x, flags
  );
endinterface

// File: rtl/fp16_classify.sv
// binary16 operand classifier (zero/inf/nan).
// Exponent 0 counts as zero, so subnormals flush.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [14:0] v,
  output cls_t        c
);
  logic [4:0] ex;
  logic       m_nz;

  assign ex   = v[14:10];
  assign m_nz = |v[9:0];

  always_comb begin
    c      = '0;
    c.zero = (ex == 5'd0);
    c.inf  = (&ex) & ~m_nz;
    c.nan  = (&ex) & m_nz;
  end
endmodule

// File: rtl/fp16_div.sv
// Iterative binary16 divider: restoring radix-2,
// one quotient bit per cycle, RNE rounding.
module fp16_div
  import fp16_pkg::*;
#(
  parameter int ITER = 13
) (
  input logic        clk,
  input logic        rst,
  fp16_div_if.slave  bus
);
  localparam int CW = $clog2(ITER + 1);

  state_t state, nxt;

  logic [CW-1:0]     cnt;
  logic              sgn;
  logic signed [6:0] e;
  logic [10:0]       dvs;
  logic [11:0]       rem;
  logic [12:0]       q;
  logic [15:0]       xr;
  logic [3:0]        fr;

  cls_t ca, cb;

  fp16_classify u_ca (
    .v (bus.a[14:0]),
    .c (ca)
  );

  fp16_classify u_cb (
    .v (bus.b[14:0]),
    .c (cb)
  );

  logic acc;
  assign acc = bus.in_valid && (state == IDLE);

  // special-case result, resolved at acceptance
  logic        sa;
  logic        spec;
  logic [15:0] sx;
  logic [3:0]  sf;

  always_comb begin
    sa   = bus.a[15] ^ bus.b[15];
    spec = 1'b1;
    sx   = {sa, 15'h0};
    sf   = 4'b0000;
    if (ca.nan | cb.nan | (ca.zero & cb.zero)
        | (ca.inf & cb.inf)) begin
      sx        = QNAN;
      sf[F_INV] = 1'b1;
    end else if (ca.inf) begin
      sx = {sa, 5'h1f, 10'h0};
    end else if (cb.zero) begin
      sx       = {sa, 5'h1f, 10'h0};
      sf[F_DZ] = 1'b1;
    end else if (cb.inf | ca.zero) begin
      sx = {sa, 15'h0};
    end else begin
      spec = 1'b0;
    end
  end

  // one restoring step
  logic [12:0] diff;
  logic        ge;
  logic [11:0] nrem;

  always_comb begin
    diff = {1'b0, rem} - {2'b00, dvs};
    ge   = ~diff[12];
    nrem = ge ? diff[11:0] : rem;
  end

  // normalise, round to nearest even, range check
  logic [9:0]        mant;
  logic              g;
  logic              st;
  logic              inc;
  logic [10:0]       msum;
  logic signed [6:0] en;
  logic signed [6:0] ef;
  logic [9:0]        mf;
  logic [15:0]       nx;
  logic [3:0]        nf;

  always_comb begin
    mant = q[12] ? q[11:2] : q[10:1];
    g    = q[12] ? q[1] : q[0];
    st   = (q[12] & q[0]) | (|rem);
    en   = q[12] ? e : e - 7'sd1;
    inc  = g & (st | mant[0]);
    msum = {1'b0, mant} + {10'h0, inc};
    ef   = msum[10] ? en + 7'sd1 : en;
    mf   = msum[10] ? 10'h0 : msum[9:0];
    nx   = {sgn, ef[4:0], mf};
    nf   = 4'b0000;
    if (ef >= $signed(7'(EXP_MAX))) begin
      nx        = {sgn, 5'h1f, 10'h0};
      nf[F_OVF] = 1'b1;
    end else if (ef <= 7'sd0) begin
      nx        = {sgn, 15'h0};
      nf[F_UNF] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = spec ? DONE : DIV;
      DIV:  if (cnt == CW'(ITER - 1)) nxt = NORM;
      NORM: nxt = DONE;
      DONE: if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sgn <= 1'b0;
      e   <= '0;
      dvs <= '0;
      rem <= '0;
      q   <= '0;
      xr  <= '0;
      fr  <= '0;
    end else begin
      unique case (state)
        IDLE: if (acc) begin
          sgn <= sa;
          e   <= $signed({2'b00, bus.a[14:10]})
               - $signed({2'b00, bus.b[14:10]})
               + 7'(BIAS);
          dvs <= {1'b1, bus.b[9:0]};
          rem <= {2'b01, bus.a[9:0]};
          q   <= '0;
          cnt <= '0;
          if (spec) begin
            xr <= sx;
            fr <= sf;
          end
        end
        DIV: begin
          rem <= nrem << 1;
          q   <= {q[11:0], ge};
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          xr <= nx;
          fr <= nf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.x         = xr;
  assign bus.flags     = fr;
endmodule

// File: tb/tb_fp16_div.sv
// Bench for fp16_div: directed cases, random operands
// against an integer-arithmetic model, stall and reset.
module tb_fp16_div;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp16_div_if bus ();

  fp16_div #(.ITER(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // returns {special, flags, x}
  function automatic logic [20:0] ref_div(
    input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, av, bv, num, t, r, m;
    logic s, za, zb, ia, ib, na, nb;
    logic [15:0] inf, zer;
    s   = a[15] ^ b[15];
    ea  = int'(a[14:10]);
    eb  = int'(b[14:10]);
    ma  = int'(a[9:0]);
    mb  = int'(b[9:0]);
    za  = (ea == 0);
    zb  = (eb == 0);
    ia  = (ea == 31) && (ma == 0);
    ib  = (eb == 31) && (mb == 0);
    na  = (ea == 31) && (ma != 0);
    nb  = (eb == 31) && (mb != 0);
    inf = {s, 5'h1f, 10'h0};
    zer = {s, 15'h0};
    if (na || nb || (za && zb) || (ia && ib))
      return {1'b1, 4'b1000, 16'h7E00};
    if (ia) return {1'b1, 4'b0000, inf};
    if (zb) return {1'b1, 4'b0100, inf};
    if (ib || za) return {1'b1, 4'b0000, zer};
    e  = ea - eb + 15;
    av = 1024 + ma;
    bv = 1024 + mb;
    if (av >= bv) num = av * 2048;
    else begin
      num = av * 4096;
      e--;
    end
    t = num / bv;
    r = num % bv;
    m = t / 2;
    if ((t % 2) == 1 && (r != 0 || (m % 2) == 1)) m++;
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e >= 31) return {1'b0, 4'b0010, inf};
    if (e <= 0) return {1'b0, 4'b0001, zer};
    return {1'b0, 4'b0000, s, 5'(e), 10'(m - 1024)};
  endfunction

  task automatic run(input string tag,
                     input logic [15:0] ta,
                     input logic [15:0] tb2,
                     input logic [15:0] ex,
                     input logic [3:0]  ef,
                     input int          elat);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".x"}, 32'(bus.x), 32'(ex));
    chk({tag, ".fl"}, 32'(bus.flags), 32'(ef));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] r;
    logic [15:0] ra, rb;
    int lat;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(bus.in_ready), 1);
    chk("rst.ov", 32'(bus.out_valid), 0);
    chk("rst.x", 32'(bus.x), 0);
    chk("rst.fl", 32'(bus.flags), 0);
    @(negedge clk);
    rst = 1'b0;

    run("3/1.5", 16'h4200, 16'h3E00, 16'h4000, 4'b0000, 14);
    run("1/3", 16'h3C00, 16'h4200, 16'h3555, 4'b0000, 14);
    run("1/0", 16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 0);
    run("0/-0", 16'h0000, 16'h8000, 16'h7E00, 4'b1000, 0);
    run("ovf", 16'h7BFF, 16'h0400, 16'h7C00, 4'b0010, 14);
    run("unf", 16'h0400, 16'h7BFF, 16'h0000, 4'b0001, 14);
    run("inf/1", 16'h7C00, 16'h3C00, 16'h7C00, 4'b0000, 0);
    run("1/inf", 16'h3C00, 16'h7C00, 16'h0000, 4'b0000, 0);
    run("nan", 16'h7C01, 16'h3C00, 16'h7E00, 4'b1000, 0);
    run("-2/2", 16'hC000, 16'h4000, 16'hBC00, 4'b0000, 14);
    run("sub", 16'h0001, 16'hBC00, 16'h8000, 4'b0000, 0);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      r  = ref_div(ra, rb);
      run($sformatf("rnd%0d", i), ra, rb, r[15:0],
          r[19:16], r[20] ? 0 : 14);
    end

    // consumer stall with competing operands
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'h4200;
    bus.b = 16'h3E00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall.lat", 32'(lat), 14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'h3C00;
      bus.b = 16'h4200;
      @(posedge clk);
      #1;
      chk("stall.x", 32'(bus.x), 32'h4000);
      chk("stall.fl", 32'(bus.flags), 0);
      chk("stall.rdy", 32'(bus.in_ready), 0);
      chk("stall.ov", 32'(bus.out_valid), 1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.ov", 32'(bus.out_valid), 0);
    chk("rel.rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("acc2.rdy", 32'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("acc2.lat", 32'(lat), 14);
    chk("acc2.x", 32'(bus.x), 32'h3555);
    @(posedge clk);
    #1;

    // reset during DIV cycle 6
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 16'h4200;
    bus.b = 16'h3E00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.rdy", 32'(bus.in_ready), 1);
    chk("mrst.ov", 32'(bus.out_valid), 0);
    chk("mrst.x", 32'(bus.x), 0);
    chk("mrst.fl", 32'(bus.flags), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk("mrst.quiet", 32'(bus.out_valid), 0);
    end
    run("post", 16'h4200, 16'h3E00, 16'h4000, 4'b0000, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
